// File: rtl/tmp101_i2c_responder_if.sv
`timescale 1ns/1ps
// Host-side signals of the TMP101 responder: address select, temperature source and status.
// The I2C pins stay discrete ports so the open-drain SDA net resolves at the board level.
interface tmp101_i2c_responder_if;
  logic [2:0] ChipSelect;
  logic [7:0] Temperature;
  logic       Busy;
  logic       Addressed;
  logic       ByteSent;
  logic       MasterNack;
  logic [7:0] Pointer;

  modport slave (
    input  ChipSelect,
    input  Temperature,
    output Busy,
    output Addressed,
    output ByteSent,
    output MasterNack,
    output Pointer
  );

  modport master (
    output ChipSelect,
    output Temperature,
    input  Busy,
    input  Addressed,
    input  ByteSent,
    input  MasterNack,
    input  Pointer
  );
endinterface

// File: rtl/tmp101_i2c_responder.sv
`timescale 1ns/1ps
// I2C slave emulating a TMP101 at address {4'b1001, ChipSelect}: returns a snapshotted
// temperature byte on reads and records the last written byte as the pointer.
module tmp101_i2c_responder #(
  parameter logic [29:0] ClockFrequency = 30'd80000000,
  parameter int unsigned SyncStages     = 2
) (
  input  logic                         clock,
  input  logic                         Reset,
  input  logic                         SCL,
  inout  wire                          SDA,
  tmp101_i2c_responder_if.slave        host
);

  localparam int unsigned Stages = (SyncStages < 2) ? 2 : SyncStages;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StTxData,
    StMasterAck,
    StRxData,
    StRxAck,
    StWaitStop
  } state_e;

  logic [Stages-1:0] scl_sync_q, sda_sync_q;
  logic              scl_prev_q, sda_prev_q;
  logic              scl_s, sda_s;
  logic              scl_rise, scl_fall, start_det, stop_det;

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] temp_snap_q, temp_snap_d;
  logic [7:0] pointer_q, pointer_d;
  logic       rw_q, rw_d;
  logic       ack_phase_q, ack_phase_d;
  logic       next_temp_q, next_temp_d;
  logic       sda_low_q, sda_low_d;
  logic       master_nack_q, master_nack_d;
  logic       addressed_q, addressed_d;
  logic       byte_sent_q, byte_sent_d;
  logic [7:0] rx_byte;

  // Synchronizers idle high so reset release on an idle bus creates no edges.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[Stages-2:0], SCL};
      sda_sync_q <= {sda_sync_q[Stages-2:0], SDA};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_s     = scl_sync_q[Stages-1];
  assign sda_s     = sda_sync_q[Stages-1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      state_q       <= StIdle;
      bit_cnt_q     <= '0;
      rx_shift_q    <= '0;
      tx_shift_q    <= '0;
      temp_snap_q   <= '0;
      pointer_q     <= '0;
      rw_q          <= 1'b0;
      ack_phase_q   <= 1'b0;
      next_temp_q   <= 1'b0;
      sda_low_q     <= 1'b0;
      master_nack_q <= 1'b0;
      addressed_q   <= 1'b0;
      byte_sent_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_shift_q    <= rx_shift_d;
      tx_shift_q    <= tx_shift_d;
      temp_snap_q   <= temp_snap_d;
      pointer_q     <= pointer_d;
      rw_q          <= rw_d;
      ack_phase_q   <= ack_phase_d;
      next_temp_q   <= next_temp_d;
      sda_low_q     <= sda_low_d;
      master_nack_q <= master_nack_d;
      addressed_q   <= addressed_d;
      byte_sent_q   <= byte_sent_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    rx_shift_d    = rx_shift_q;
    tx_shift_d    = tx_shift_q;
    temp_snap_d   = temp_snap_q;
    pointer_d     = pointer_q;
    rw_d          = rw_q;
    ack_phase_d   = ack_phase_q;
    next_temp_d   = next_temp_q;
    sda_low_d     = sda_low_q;
    master_nack_d = master_nack_q;
    addressed_d   = 1'b0;
    byte_sent_d   = 1'b0;
    rx_byte       = {rx_shift_q[6:0], sda_s};

    if (start_det) begin
      state_d       = StAddr;
      bit_cnt_d     = '0;
      sda_low_d     = 1'b0;
      master_nack_d = 1'b0;
      ack_phase_d   = 1'b0;
    end else if (stop_det) begin
      state_d   = StIdle;
      sda_low_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StWaitStop: sda_low_d = 1'b0;
        StAddr: begin
          if (scl_rise) begin
            rx_shift_d = rx_byte;
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (rx_byte[7:1] == {4'b1001, host.ChipSelect}) begin
                addressed_d = 1'b1;
                tx_shift_d  = host.Temperature;
                temp_snap_d = host.Temperature;
                rw_d        = rx_byte[0];
                next_temp_d = 1'b0;
                ack_phase_d = 1'b0;
                state_d     = StAddrAck;
              end else begin
                state_d = StWaitStop;
              end
            end
          end
        end
        // First fall starts the ACK bit, second fall ends it.
        StAddrAck, StRxAck: begin
          if (scl_fall) begin
            if (!ack_phase_q) begin
              sda_low_d   = 1'b1;
              ack_phase_d = 1'b1;
            end else begin
              ack_phase_d = 1'b0;
              bit_cnt_d   = '0;
              if (state_q == StAddrAck && rw_q) begin
                state_d   = StTxData;
                sda_low_d = ~tx_shift_q[7];
              end else begin
                state_d   = StRxData;
                sda_low_d = 1'b0;
              end
            end
          end
        end
        StTxData: begin
          if (scl_fall) begin
            if (bit_cnt_q == 3'd7) begin
              sda_low_d = 1'b0;
              state_d   = StMasterAck;
            end else begin
              tx_shift_d = {tx_shift_q[6:0], 1'b0};
              sda_low_d  = ~tx_shift_q[6];
              bit_cnt_d  = bit_cnt_q + 3'd1;
            end
          end
        end
        StMasterAck: begin
          if (scl_rise) begin
            master_nack_d = sda_s;
            byte_sent_d   = 1'b1;
            if (sda_s) begin
              state_d = StWaitStop;
            end else begin
              tx_shift_d  = next_temp_q ? temp_snap_q : 8'h00;
              next_temp_d = ~next_temp_q;
            end
          end else if (scl_fall) begin
            state_d   = StTxData;
            sda_low_d = ~tx_shift_q[7];
            bit_cnt_d = '0;
          end
        end
        StRxData: begin
          if (scl_rise) begin
            rx_shift_d = rx_byte;
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              pointer_d   = rx_byte;
              ack_phase_d = 1'b0;
              state_d     = StRxAck;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign SDA             = sda_low_q ? 1'b0 : 1'bz;
  assign host.Busy       = (state_q != StIdle);
  assign host.Addressed  = addressed_q;
  assign host.ByteSent   = byte_sent_q;
  assign host.MasterNack = master_nack_q;
  assign host.Pointer    = pointer_q;

endmodule

// File: tb/tb_tmp101_i2c_responder.sv
`timescale 1ns/1ps
// Directed bench for tmp101_i2c_responder: a bit-banged I2C master with hand-computed
// expected bytes, ACK bits and status pulses.
module tb_tmp101_i2c_responder;

  localparam int unsigned Q = 100;  // quarter SCL period; SCL = 400 ns, clock = 10 ns

  logic clock = 1'b0;
  logic Reset;
  logic scl;
  logic m_sda_low;
  wire  sda_line;

  pullup (sda_line);
  assign sda_line = m_sda_low ? 1'b0 : 1'bz;

  tmp101_i2c_responder_if host ();

  tmp101_i2c_responder #(
    .ClockFrequency(30'd80000000),
    .SyncStages    (2)
  ) dut (
    .clock(clock),
    .Reset(Reset),
    .SCL  (scl),
    .SDA  (sda_line),
    .host (host)
  );

  always #5 clock = ~clock;

  int unsigned addr_cnt = 0;
  int unsigned sent_cnt = 0;
  int unsigned drv_cnt  = 0;

  always @(posedge clock) begin
    if (host.Addressed) addr_cnt <= addr_cnt + 1;
    if (host.ByteSent)  sent_cnt <= sent_cnt + 1;
    if (!sda_line && !m_sda_low) drv_cnt <= drv_cnt + 1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic i2c_bit(input logic b, output logic r);
    m_sda_low = ~b;
    #Q;
    scl = 1'b1;
    #Q;
    r = sda_line;
    #Q;
    scl = 1'b0;
    #Q;
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b1;
    #Q;
    scl = 1'b0;
    #Q;
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1;
    #Q;
    scl = 1'b1;
    #Q;
    m_sda_low = 1'b0;
    #Q;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) i2c_bit(b[i], r);
    i2c_bit(1'b1, ack);
  endtask

  task automatic recv_byte(input logic nack, input int chg_at, input logic [7:0] chg_val,
                           output logic [7:0] d);
    logic r;
    d = '0;
    for (int i = 7; i >= 0; i--) begin
      if (i == chg_at) host.Temperature = chg_val;
      i2c_bit(1'b1, r);
      d[i] = r;
    end
    i2c_bit(nack, r);
  endtask

  initial begin
    logic        ack;
    logic        r;
    logic [7:0]  d;
    int unsigned a0, s0, v0;

    Reset            = 1'b0;
    scl              = 1'b1;
    m_sda_low        = 1'b0;
    host.ChipSelect  = 3'b101;
    host.Temperature = 8'h19;
    #100;
    check_eq("rst_sda", sda_line, 1'b1);
    check_eq("rst_busy", host.Busy, 1'b0);
    check_eq("rst_pointer", host.Pointer, 8'h00);
    check_eq("rst_nack", host.MasterNack, 1'b0);
    check_eq("rst_addressed", host.Addressed, 1'b0);
    check_eq("rst_bytesent", host.ByteSent, 1'b0);
    Reset = 1'b1;
    #200;
    check_eq("idle_busy", host.Busy, 1'b0);

    // Single-byte read, NACKed
    a0 = addr_cnt; s0 = sent_cnt;
    i2c_start();
    send_byte(8'h9B, ack);
    check_eq("rd1_addr_ack", ack, 1'b0);
    check_eq("rd1_busy", host.Busy, 1'b1);
    recv_byte(1'b1, -1, 8'h00, d);
    check_eq("rd1_data", d, 8'h19);
    i2c_stop();
    #200;
    check_eq("rd1_busy_end", host.Busy, 1'b0);
    check_eq("rd1_nack", host.MasterNack, 1'b1);
    check_eq("rd1_addressed", addr_cnt - a0, 1);
    check_eq("rd1_bytesent", sent_cnt - s0, 1);

    // Wrong address: never driven, no pulses
    a0 = addr_cnt; v0 = drv_cnt;
    i2c_start();
    send_byte(8'h93, ack);
    check_eq("bad_addr_ack", ack, 1'b1);
    check_eq("nack_clr_on_start", host.MasterNack, 1'b0);
    recv_byte(1'b1, -1, 8'h00, d);
    check_eq("bad_data", d, 8'hFF);
    i2c_stop();
    #200;
    check_eq("bad_drv", drv_cnt - v0, 0);
    check_eq("bad_addressed", addr_cnt - a0, 0);
    check_eq("bad_busy_end", host.Busy, 1'b0);

    // Three-byte read; Temperature changes mid byte 0 but snapshot holds
    host.Temperature = 8'h19;
    s0 = sent_cnt;
    i2c_start();
    send_byte(8'h9B, ack);
    check_eq("rd3_addr_ack", ack, 1'b0);
    recv_byte(1'b0, 4, 8'h30, d);
    check_eq("rd3_byte0", d, 8'h19);
    recv_byte(1'b0, -1, 8'h00, d);
    check_eq("rd3_byte1", d, 8'h00);
    check_eq("rd3_nack_mid", host.MasterNack, 1'b0);
    recv_byte(1'b1, -1, 8'h00, d);
    check_eq("rd3_byte2", d, 8'h19);
    i2c_stop();
    #200;
    check_eq("rd3_bytesent", sent_cnt - s0, 3);
    check_eq("rd3_nack", host.MasterNack, 1'b1);

    // Write pointer
    s0 = sent_cnt;
    i2c_start();
    send_byte(8'h9A, ack);
    check_eq("wr_addr_ack", ack, 1'b0);
    send_byte(8'h01, ack);
    check_eq("wr_data_ack", ack, 1'b0);
    i2c_stop();
    #200;
    check_eq("wr_pointer", host.Pointer, 8'h01);
    check_eq("wr_bytesent", sent_cnt - s0, 0);
    check_eq("wr_busy_end", host.Busy, 1'b0);

    // Reset during bit 3 of a data byte while SDA is driven low (0x42 bit 3 = 0)
    host.Temperature = 8'h42;
    i2c_start();
    send_byte(8'h9B, ack);
    check_eq("mr_addr_ack", ack, 1'b0);
    for (int i = 0; i < 4; i++) i2c_bit(1'b1, r);
    m_sda_low = 1'b0;
    #Q;
    scl = 1'b1;
    #Q;
    check_eq("mr_sda_driven", sda_line, 1'b0);
    Reset = 1'b0;
    #1;
    check_eq("mr_sda_released", sda_line, 1'b1);
    check_eq("mr_busy", host.Busy, 1'b0);
    #99;
    Reset = 1'b1;
    #200;
    host.Temperature = 8'h19;
    i2c_start();
    send_byte(8'h9B, ack);
    check_eq("post_addr_ack", ack, 1'b0);
    recv_byte(1'b1, -1, 8'h00, d);
    check_eq("post_data", d, 8'h19);
    i2c_stop();
    #200;
    check_eq("post_busy_end", host.Busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tmp101_i2c_responder.md
# tmp101_i2c_responder

Synthesizable I2C slave that emulates a TMP101 temperature sensor on the shared SCL/SDA bus. It answers the 7-bit address `{4'b1001, ChipSelect}`. On read transactions it returns a temperature byte supplied by the design. The block lets the board-level temperature-reader master be exercised in simulation, or on a second FPGA, without a physical sensor.

## Interface
Parameters:
- ClockFrequency, 30'd80000000: system clock in Hz; documentation only, no logic depends on it.
- SyncStages, 2: synchronizer flops on SCL and SDA; minimum 2.

Ports:
- clock  input  1  system clock, all state on the rising edge.
- Reset  input  1  **asynchronous, active-low** reset.
- SCL  input  1  I2C clock from the master. The responder never stretches SCL.
- SDA  inout  1  open-drain data line. The block only ever drives 1'b0 or 1'bz.
- ChipSelect  input  3  low address bits A2..A0.
- Temperature  input  8  Celsius byte returned as read byte 0.
- Busy  output  1  high while the state is not IDLE.
- Addressed  output  1  one-clock pulse on an address match, before the ACK is driven.
- ByteSent  output  1  one-clock pulse after each transmitted byte's master ACK/NACK is sampled.
- MasterNack  output  1  level; 1 if the last transmitted byte was NACKed. Cleared on the next START.
- Pointer  output  8  last byte written by a master write transaction.

## Operation
- SCL and SDA each pass through SyncStages flops. Rise and fall detection uses the last two synchronized samples. All decisions below use the synchronized signals.
- START is SDA falling while SCL is high. STOP is SDA rising while SCL is high.
  - START in any state, including a repeated START, goes to ADDR with bit counter = 0 and SDA released.
  - STOP in any state goes to IDLE with SDA released.
- States:
  - IDLE: SDA released; wait for START.
  - ADDR:
    - Shift SDA in, MSB first, on each SCL rise.
    - After 8 bits, compare bits [7:1] with `{4'b1001, ChipSelect}`.
    - On a match: pulse Addressed, latch Temperature into TxShift, latch bit 0 as RW, go to ADDR_ACK.
    - On a mismatch: go to WAIT_STOP without driving SDA.
  - ADDR_ACK:
    - On the SCL fall after bit 8, drive SDA low.
    - On the next SCL fall, go to TX_DATA if RW=1, or RX_DATA if RW=0.
  - TX_DATA:
    - On entry and on each SCL fall, present the next TxShift bit, MSB first. Drive 0 as low and 1 as release.
    - After the SCL fall that ends bit 0, release SDA and go to MASTER_ACK.
  - MASTER_ACK:
    - On SCL rise, sample SDA, set MasterNack = SDA, and pulse ByteSent.
    - On ACK: load the next byte (byte index 1 = 8'h00, then alternate Temperature snapshot / 8'h00) and go to TX_DATA on the SCL fall.
    - On NACK: go to WAIT_STOP.
  - RX_DATA:
    - Shift 8 bits in on SCL rise, then load Pointer.
    - Drive the ACK low for the ninth clock, exactly as in ADDR_ACK, then return to RX_DATA.
  - WAIT_STOP: SDA released; wait for STOP (to IDLE) or START (to ADDR).
- The Temperature snapshot is taken once per address match. Changes on Temperature during a read do not affect bytes already in flight.
- Reset values: state IDLE, SDA = z, Busy = 0, Addressed = 0, ByteSent = 0, MasterNack = 0, Pointer = 8'h00, shift registers = 0.

## Timing
- Input-to-decision latency is SyncStages+1 clocks after the pin edge.
- SDA changes on the clock after a detected SCL fall. At 80 MHz this gives about 37.5 ns from the SCL pin fall, well inside the SCL low time.
- The clock must be at least 16× the SCL rate; 80 MHz vs 20 kHz meets this.
- The SCL rise sample is taken in the cycle the rise is detected.
- Addressed and ByteSent are exactly one clock wide.
- Simultaneous events: START/STOP detection has priority over bit shifting in the same cycle. A SDA change while SCL is high is never treated as a data bit.
- Reset assertion mid-byte releases SDA asynchronously, with no clock needed.

## Test plan
- Reset held low -> SDA = z, Busy = 0, Pointer = 8'h00. Release with SCL = SDA = 1 -> remains IDLE.
- ChipSelect = 3'b101, Temperature = 8'h19; master sends START, 0x9B, reads 1 byte, NACK, STOP:
  - address ACK bit reads 0, data reads 0x19;
  - ByteSent pulses once, MasterNack = 1;
  - Busy = 0 after STOP.
- Same setup but the master addresses 0x93 -> SDA never driven low, ACK bit reads 1, Addressed never pulses, Busy = 0 after STOP.
- Two-byte read with master ACK after byte 0 -> bytes 0x19, 0x00. Changing Temperature to 8'h30 mid-byte-0 still yields 0x19.
- Write START, 0x9A, 0x01, STOP -> both bytes ACKed (SDA low on the 9th clocks), Pointer = 8'h01, nothing transmitted.
- Reset asserted during bit 3 of a data byte with SDA driven low -> SDA = z immediately, state IDLE. A following full read returns the correct byte.
